amns_host_port: RTL and testbench

Host-side port of the shared operand/result BRAM used by the AMNS Montgomery multiplier. It accepts a 32-bit valid/ready input stream and writes operand words A, B, M and M'0 into the BRAM in the multiplier's memory layout. It then pulses the core start, waits for core completion and streams the RES words back out over a 32-bit valid/ready output stream with backpressure. It sits on the BRAM port opposite the core's poly_memory block and drives the same address map.

---
 rtl/amns_pkg.sv | 39 +++
 rtl/amns_skid_fifo.sv | 48 ++++
 rtl/amns_host_port.sv | 140 ++++++++++++++
 tb/tb_amns_host_port.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amns_pkg.sv
// Shared definitions for the AMNS operand/result BRAM. The host port and the
// core's poly_memory both use this address map, so the two ends agree on it.
//   - default geometry (word width, coefficients, blocks per coefficient)
//   - address-map bases and word counts for the default geometry
//   - helpers that derive the map for any N/S
//   - the host-port state encoding
package amns_pkg;

  localparam int DEF_WORD_WIDTH = 17;
  localparam int DEF_N          = 5;
  localparam int DEF_S          = 4;

  // Address width needed for the full map (operands + M'0 + RES).
  function automatic int addr_len_f(input int n, input int s);
    return $clog2(4*n*s + n) + 1;
  endfunction

  // RES follows A, B, M and M'0; that is also the number of words loaded.
  function automatic int res_base_f(input int n, input int s);
    return 3*n*s + n;
  endfunction

  localparam int A_BASE   = 0;
  localparam int B_BASE   = DEF_N*DEF_S;
  localparam int M_BASE   = 2*DEF_N*DEF_S;
  localparam int MP0_BASE = 3*DEF_N*DEF_S;
  localparam int RES_BASE = 3*DEF_N*DEF_S + DEF_N;
  localparam int LOAD_CNT = 3*DEF_N*DEF_S + DEF_N;
  localparam int RES_CNT  = DEF_N*DEF_S;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_READ
  } amns_state_t;

endpackage

// File: rtl/amns_skid_fifo.sv
// Two-entry FIFO holding RES words (data plus last flag) on their way out.
//   clock, reset : clock, synchronous active-high reset (flushes entries)
//   push, push_data : write an entry (taken when not full, or when popping)
//   pop          : drop the head entry (ignored when empty)
//   head         : current head entry
//   full, count  : occupancy
module amns_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_idx;
  logic         rd_idx;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (do_pop)
        rd_idx <= ~rd_idx;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/amns_host_port.sv
// Host-side port of the AMNS multiplier's operand/result BRAM.
// Loads A, B, M, M'0 from a 32-bit valid/ready stream into the BRAM, starts
// the core, waits for completion and streams RES back out with backpressure.
//   clock, reset          : clock, synchronous active-high reset
//   s_data_i/s_valid_i/s_ready_o           : operand input stream
//   m_data_o/m_valid_o/m_last_o/m_ready_i  : RES output stream
//   BRAM_we_o/BRAM_addr_o/BRAM_din_o/BRAM_dout_i : BRAM port (1-cycle read)
//   core_start_o, core_done_i : core handshake
//   busy_o                : high whenever not idle
module amns_host_port
  import amns_pkg::*;
#(
  parameter  int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter  int N          = DEF_N,
  parameter  int S          = DEF_S,
  localparam int ADDR_LEN   = addr_len_f(N, S)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [31:0]         m_data_o,
  output logic                m_valid_o,
  output logic                m_last_o,
  input  logic                m_ready_i,
  output logic                BRAM_we_o,
  output logic [ADDR_LEN-1:0] BRAM_addr_o,
  output logic [31:0]         BRAM_din_o,
  input  logic [31:0]         BRAM_dout_i,
  output logic                core_start_o,
  input  logic                core_done_i,
  output logic                busy_o
);

  localparam logic [ADDR_LEN-1:0] LOAD_LAST = ADDR_LEN'(res_base_f(N, S) - 1);
  localparam logic [ADDR_LEN-1:0] RES_FIRST = ADDR_LEN'(res_base_f(N, S));
  localparam logic [ADDR_LEN-1:0] RES_LAST  = ADDR_LEN'(res_base_f(N, S) + N*S - 1);

  amns_state_t         state;
  logic [ADDR_LEN-1:0] wr_ptr;
  logic [ADDR_LEN-1:0] rd_ptr;
  logic [ADDR_LEN-1:0] addr_q;
  logic                start_q;
  logic                infl;
  logic                infl_last;
  logic                accept;
  logic                issue;
  logic                pop;
  logic [32:0]         head;
  logic [1:0]          count;
  logic                fifo_full;
  logic [2:0]          committed;

  // High bits of the data buses are don't-care by design.
  logic unused_bits;
  assign unused_bits = ^{s_data_i[31:WORD_WIDTH], BRAM_dout_i[31:WORD_WIDTH], fifo_full};

  assign s_ready_o    = (state == ST_IDLE) || (state == ST_LOAD);
  assign accept       = s_valid_i && s_ready_o;
  assign busy_o       = (state != ST_IDLE);
  assign core_start_o = start_q;

  assign m_valid_o = (count != 2'd0);
  assign m_data_o  = m_valid_o ? head[31:0] : 32'd0;
  assign m_last_o  = m_valid_o && head[32];
  assign pop       = m_valid_o && m_ready_i;

  // Words buffered or on their way back from the BRAM. A pop this cycle frees
  // a slot before the new read's data can arrive, keeping one read per cycle.
  assign committed = 3'(count) + 3'(infl);
  assign issue     = (state == ST_READ) && (rd_ptr <= RES_LAST) &&
                     (committed < 3'd2 + 3'(pop));

  always_comb begin
    BRAM_we_o   = accept;
    BRAM_addr_o = addr_q;
    BRAM_din_o  = 32'd0;
    if (accept) begin
      BRAM_addr_o = (state == ST_IDLE) ? ADDR_LEN'(A_BASE) : wr_ptr;
      BRAM_din_o  = 32'(s_data_i[WORD_WIDTH-1:0]);
    end else if (issue) begin
      BRAM_addr_o = rd_ptr;
    end
  end

  amns_skid_fifo #(.W(33)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (infl),
    .push_data ({infl_last, 32'(BRAM_dout_i[WORD_WIDTH-1:0])}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      addr_q    <= '0;
      start_q   <= 1'b0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      addr_q    <= BRAM_addr_o;
      start_q   <= 1'b0;
      infl      <= issue;
      infl_last <= issue && (rd_ptr == RES_LAST);
      unique case (state)
        ST_IDLE: if (accept) begin
          wr_ptr <= ADDR_LEN'(1);
          state  <= ST_LOAD;
        end
        ST_LOAD: if (accept) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LOAD_LAST) begin
            state   <= ST_START;
            start_q <= 1'b1;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: if (core_done_i) begin
          state  <= ST_READ;
          rd_ptr <= RES_FIRST;
        end
        ST_READ: begin
          if (issue)
            rd_ptr <= rd_ptr + 1'b1;
          if (pop && head[32])
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amns_host_port.sv
module tb_amns_host_port;

  localparam int LCNT  = 65;
  localparam int RCNT  = 20;
  localparam int RBASE = 65;
  localparam logic [31:0] MASK = 32'h0001_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_last_o;
  logic        m_ready_i = 1'b1;
  logic        BRAM_we_o;
  logic [7:0]  BRAM_addr_o;
  logic [31:0] BRAM_din_o;
  logic [31:0] bram_dout = '0;
  logic        core_start_o;
  logic        core_done_i = 1'b0;
  logic        busy_o;

  always #5 clock = ~clock;

  amns_host_port #(.WORD_WIDTH(17), .N(5), .S(4)) dut (
    .clock(clock), .reset(reset),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .BRAM_we_o(BRAM_we_o), .BRAM_addr_o(BRAM_addr_o), .BRAM_din_o(BRAM_din_o),
    .BRAM_dout_i(bram_dout), .core_start_o(core_start_o), .core_done_i(core_done_i),
    .busy_o(busy_o)
  );

  // BRAM model: RES region content is owned by the bench (stands in for the core).
  logic [31:0] mem [0:255];
  logic [31:0] res_val [0:RCNT-1];
  always @(posedge clock) begin
    if (BRAM_we_o) mem[BRAM_addr_o] <= BRAM_din_o;
    bram_dout <= (BRAM_addr_o >= 8'd65 && BRAM_addr_o <= 8'd84) ?
                 res_val[BRAM_addr_o - 8'd65] : mem[BRAM_addr_o];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- scoreboards ----------------
  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] d; logic l; } rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  logic [31:0] model [0:LCNT-1];

  int wr_first, wr_last, wr_count, start_cnt, start_cyc;

  always @(negedge clock) begin : wmon
    wr_t e;
    if (!reset) begin
      if (BRAM_we_o) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", BRAM_addr_o, e.addr);
          chk("wr_data", BRAM_din_o, e.data);
        end
        if (wr_count == 0) wr_first = cyc;
        wr_last = cyc;
        wr_count++;
      end
      if (core_start_o) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  int rd_popped, rd_hi, first_valid_cyc, done_cyc;
  bit read_phase = 0, hold = 0, chk_busy_drop = 0;
  logic [31:0] hold_d;
  logic hold_l;

  always @(negedge clock) begin : rmon
    rd_t e;
    if (reset) begin
      hold = 0;
      chk_busy_drop = 0;
    end else begin
      if (chk_busy_drop) begin
        chk("busy_drop", busy_o, 0);
        chk_busy_drop = 0;
      end
      if (hold) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, hold_d);
        chk("hold_last", m_last_o, hold_l);
      end
      hold = 0;
      if (m_valid_o) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_ready_i) begin
          if (exp_rd.size() == 0) fail_now("unexpected_output");
          else begin
            e = exp_rd.pop_front();
            chk("out_data", m_data_o, e.d);
            chk("out_last", m_last_o, e.l);
            if (e.l) begin
              chk("busy_at_last", busy_o, 1);
              chk_busy_drop = 1;
            end
          end
          rd_popped++;
        end else begin
          hold = 1;
          hold_d = m_data_o;
          hold_l = m_last_o;
        end
      end
      if (read_phase) begin
        if (busy_o && BRAM_addr_o >= 8'd65 && BRAM_addr_o <= 8'd84 && int'(BRAM_addr_o) > rd_hi)
          rd_hi = int'(BRAM_addr_o);
        chk("outstanding_le2", (rd_hi - (RBASE - 1) - rd_popped) <= 2, 1);
      end
    end
  end

  // m_ready driver: 0 = stalled, 1 = always ready, other = random 50%.
  int rdy_mode = 1;
  initial forever begin
    @(posedge clock); #1;
    case (rdy_mode)
      0: m_ready_i = 1'b0;
      1: m_ready_i = 1'b1;
      default: m_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus tasks (entered at #1 after a rising edge) ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, BRAM_we_o, 0);
    chk({tag, "_addr"}, BRAM_addr_o, 0);
    chk({tag, "_din"}, BRAM_din_o, 0);
    chk({tag, "_start"}, core_start_o, 0);
    chk({tag, "_mvalid"}, m_valid_o, 0);
    chk({tag, "_mlast"}, m_last_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_sready"}, s_ready_o, 1);
  endtask

  task automatic do_load(input bit gaps, input bit spurious_done);
    wr_count = 0;
    start_cnt = 0;
    for (int i = 0; i < LCNT; i++) begin
      while ((gaps && $urandom_range(0, 2) == 0) || (spurious_done && i == 30 && core_done_i == 0)) begin
        s_valid_i = 1'b0;
        s_data_i = $urandom;
        core_done_i = spurious_done && (i == 30 || $urandom_range(0, 1) == 1);
        @(posedge clock); #1;
        if (i == 30) break;
      end
      core_done_i = 1'b0;
      s_valid_i = 1'b1;
      s_data_i = $urandom;
      model[i] = s_data_i & MASK;
      exp_wr.push_back('{i, s_data_i & MASK});
      @(negedge clock);
      chk("s_ready_load", s_ready_o, 1);
      @(posedge clock); #1;
    end
    s_valid_i = 1'b0;
    core_done_i = 1'b0;
  endtask

  task automatic check_mem();
    for (int i = 0; i < LCNT; i++) chk("bram_content", mem[i], model[i]);
  endtask

  task automatic do_read(input int wait_cyc, input int mode, input int stop_after);
    rdy_mode = mode;
    rd_popped = 0;
    rd_hi = RBASE - 1;
    first_valid_cyc = -1;
    exp_rd.delete();
    for (int k = 0; k < RCNT; k++) begin
      res_val[k] = $urandom;
      exp_rd.push_back('{res_val[k] & MASK, k == RCNT - 1});
    end
    repeat (wait_cyc) begin @(posedge clock); #1; end
    core_done_i = 1'b1;
    @(negedge clock);
    done_cyc = cyc + 1;
    read_phase = 1;
    @(posedge clock); #1;
    core_done_i = 1'b0;
    if (mode == 0) begin
      repeat (12) @(posedge clock);
      @(negedge clock);
      chk("stall_reads_issued", rd_hi - (RBASE - 1), 2);
      chk("stall_valid", m_valid_o, 1);
      rdy_mode = 1;
    end
    for (int t = 0; t < 400 && rd_popped < stop_after; t++) @(posedge clock);
    #1;
    if (rd_popped < stop_after) fail_now("read_timeout");
    chk("first_valid_latency", first_valid_cyc, done_cyc + 2);
    if (stop_after == RCNT) begin
      @(posedge clock); #1;
      chk("all_words_delivered", exp_rd.size(), 0);
      chk("idle_after_read", busy_o, 0);
      read_phase = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < RCNT; k++) res_val[k] = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("in_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("after_reset");
    @(posedge clock); #1;

    // 1: back-to-back load, spurious valid in WAIT, read with m_ready high.
    do_load(0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("load_write_count", wr_count, LCNT);
    chk("load_span", wr_last - wr_first, LCNT - 1);
    chk("start_cycle", start_cyc, wr_last + 1);
    chk("start_once", start_cnt, 1);
    chk("busy_in_wait", busy_o, 1);
    check_mem();
    for (int i = 0; i < 5; i++) begin
      s_valid_i = 1'b1;
      s_data_i = $urandom;
      @(negedge clock);
      chk("s_ready_wait", s_ready_o, 0);
      @(posedge clock); #1;
    end
    s_valid_i = 1'b0;
    do_read(10, 1, RCNT);
    chk("start_once_total", start_cnt, 1);

    // 2: gappy load with spurious done, read with random backpressure.
    do_load(1, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("gap_write_count", wr_count, LCNT);
    chk("gap_start_once", start_cnt, 1);
    check_mem();
    do_read(4, 2, RCNT);

    // 3: full stall at read start, then release.
    do_load(0, 0);
    do_read(3, 0, RCNT);

    // 4: reset mid-READ, then a fresh load and read.
    do_load(0, 0);
    do_read(2, 1, 7);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_vals("mid_read_reset");
    read_phase = 0;
    exp_rd.delete();
    exp_wr.delete();
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("post_mid_reset");
    @(posedge clock); #1;
    do_load(0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("reload_start_once", start_cnt, 1);
    check_mem();
    do_read(5, 2, RCNT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
